// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared VGA constants: default 640x480 @ 60 Hz timing, total-length helper,
// coordinate and colour widths used by the timing and colour generators.
// No ports.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 4;

    typedef logic [COORD_W-1:0] coord_t;
    // One bit wider than a coordinate so region bounds of exactly 1024 compare
    // correctly.
    typedef logic [COORD_W:0]   coord_ext_t;

    localparam int DEF_CLK_DIV  = 4;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Clock-enable generator: tick is a one-clk pulse every CLK_DIV clocks.
// Also usable as a slow sample strobe (button sampling, debouncing).
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-low reset
//   tick  out  high for one clk while the divider sits at CLK_DIV-1
//
// CLK_DIV legal range 1..16; CLK_DIV=1 gives tick constantly 1 after reset.
// -----------------------------------------------------------------------------
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef logic [DIV_W-1:0] div_t;
    localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be in 1..16");
    end

    div_t divider;
    div_t divider_nxt;

    always_comb begin
        divider_nxt = divider + 1'b1;
        if (divider == DIV_LAST) begin
            divider_nxt = '0;
        end
    end

    // tick is registered from the next divider value so it is high exactly
    // while divider==CLK_DIV-1, and still reads 0 during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divider <= '0;
            tick    <= 1'b0;
        end else begin
            divider <= divider_nxt;
            tick    <= (divider_nxt == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing from the system clock: pixel-rate clock enable,
// hcount/vcount raster counters and registered sync/blanking/frame decode.
// Decode is computed from the next counter values, so it is always aligned
// with hcount/vcount.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   asynchronous, active-low reset
//   pixel_en     out  one-clk pulse every CLK_DIV clocks (pixel slot)
//   hcount       out  pixel column, 0..H_TOTAL-1
//   vcount       out  line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, asserted level SYNC_ACTIVE
//   vsync        out  vertical sync, asserted level SYNC_ACTIVE
//   blanking     out  1 outside the visible area
//   frame_start  out  one-clk pulse after the raster wraps to (0,0)
//   frame_count  out  8-bit frame counter (only with VGA_FRAME_COUNT_EN)
//
// Build option: define VGA_FRAME_COUNT_EN to add the frame_count port.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pixel_en,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               blanking,
    output logic               frame_start
`ifdef VGA_FRAME_COUNT_EN
   ,output logic [7:0]         frame_count
`endif
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    localparam coord_t     H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t     V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_ext_t H_VIS_END  = coord_ext_t'(H_ACTIVE);
    localparam coord_ext_t V_VIS_END  = coord_ext_t'(V_ACTIVE);
    localparam coord_ext_t HS_START   = coord_ext_t'(H_ACTIVE + H_FP);
    localparam coord_ext_t HS_END     = coord_ext_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_ext_t VS_START   = coord_ext_t'(V_ACTIVE + V_FP);
    localparam coord_ext_t VS_END     = coord_ext_t'(V_ACTIVE + V_FP + V_SYNC);

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (pixel_en)
    );

    coord_t     h_nxt;
    coord_t     v_nxt;
    coord_ext_t h_ext;
    coord_ext_t v_ext;
    logic       wrap_nxt;
    logic       blank_nxt;
    logic       hs_on_nxt;
    logic       vs_on_nxt;

    always_comb begin
        h_nxt    = hcount;
        v_nxt    = vcount;
        wrap_nxt = 1'b0;
        if (pixel_en) begin
            if (hcount == H_LAST) begin
                h_nxt = '0;
                if (vcount == V_LAST) begin
                    v_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    v_nxt = vcount + 1'b1;
                end
            end else begin
                h_nxt = hcount + 1'b1;
            end
        end

        h_ext     = {1'b0, h_nxt};
        v_ext     = {1'b0, v_nxt};
        blank_nxt = (h_ext >= H_VIS_END) || (v_ext >= V_VIS_END);
        hs_on_nxt = (h_ext >= HS_START) && (h_ext < HS_END);
        vs_on_nxt = (v_ext >= VS_START) && (v_ext < VS_END);
    end

    // Decode registers load every clk from the next counter values; between
    // pixel slots the counters hold, so the decode holds too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount      <= '0;
            vcount      <= '0;
            blanking    <= 1'b1;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            blanking    <= blank_nxt;
            hsync       <= hs_on_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= vs_on_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            frame_start <= wrap_nxt;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count <= '0;
        end else if (frame_start) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst_s = 1'b0;

    logic       pixel_en, hsync, vsync, blanking, frame_start;
    logic [9:0] hcount, vcount;
    logic       pixel_en_s, hsync_s, vsync_s, blanking_s, frame_start_s;
    logic [9:0] hcount_s, vcount_s;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count, frame_count_s;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Default build: 640x480, CLK_DIV=4, active-low syncs.
    vga_timing_gen u_dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_en    (pixel_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .blanking    (blanking),
        .frame_start (frame_start)
`ifdef VGA_FRAME_COUNT_EN
       ,.frame_count (frame_count)
`endif
    );

    // Tiny raster (15x8, 120 clks/frame), CLK_DIV=1, active-high syncs.
    vga_timing_gen #(
        .CLK_DIV     (1),
        .H_ACTIVE    (8),
        .H_FP        (2),
        .H_SYNC      (3),
        .H_BP        (2),
        .V_ACTIVE    (4),
        .V_FP        (1),
        .V_SYNC      (2),
        .V_BP        (1),
        .SYNC_ACTIVE (1'b1)
    ) u_small (
        .clk         (clk),
        .rst         (rst_s),
        .pixel_en    (pixel_en_s),
        .hcount      (hcount_s),
        .vcount      (vcount_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .blanking    (blanking_s),
        .frame_start (frame_start_s)
`ifdef VGA_FRAME_COUNT_EN
       ,.frame_count (frame_count_s)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low_clks;
        int he, ve, p;
        int hs_cnt, vs_cnt, fs_cnt;

        repeat (3) tick();
        check("rst_pixel_en", pixel_en, 0);
        check("rst_hcount", hcount, 0);
        check("rst_vcount", vcount, 0);
        check("rst_blanking", blanking, 1);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_frame_start", frame_start, 0);
        check("rst_s_hsync", hsync_s, 0);
        check("rst_s_vsync", vsync_s, 0);
        check("rst_s_pixel_en", pixel_en_s, 0);

        // Release: pixel_en high during the 4th clk, hcount=1 after that edge.
        @(negedge clk) rst = 1'b1;
        tick();
        check("rel1_pixel_en", pixel_en, 0);
        check("rel1_hcount", hcount, 0);
        check("rel1_blanking", blanking, 0);
        check("rel1_hsync", hsync, 1);
        tick();
        check("rel2_pixel_en", pixel_en, 0);
        tick();
        check("rel3_pixel_en", pixel_en, 1);
        check("rel3_hcount", hcount, 0);
        tick();
        check("rel4_pixel_en", pixel_en, 0);
        check("rel4_hcount", hcount, 1);
        repeat (3) tick();
        check("rel7_pixel_en", pixel_en, 1);
        tick();
        check("rel8_hcount", hcount, 2);

        // Rest of line 0 plus the wrap into line 1.
        hs_low_clks = 0;
        for (int h = 3; h <= 800; h++) begin
            repeat (4) begin
                tick();
                if (hsync == 1'b0) hs_low_clks++;
            end
            he = h % 800;
            check("line_hcount", hcount, he);
            check("line_blanking", blanking, (he >= 640) ? 1 : 0);
            check("line_hsync", hsync, (he >= 656 && he <= 751) ? 0 : 1);
        end
        check("hsync_low_clks", hs_low_clks, 384);
        check("wrap_vcount", vcount, 1);
        check("wrap_vsync", vsync, 1);
        check("wrap_frame_start", frame_start, 0);

        // Mid-frame async reset.
        repeat (1200) tick();
        check("pre_rst_hcount", hcount, 300);
        check("pre_rst_vcount", vcount, 1);
        #3 rst = 1'b0;
        #1;
        check("arst_hcount", hcount, 0);
        check("arst_vcount", vcount, 0);
        check("arst_blanking", blanking, 1);
        check("arst_hsync", hsync, 1);
        check("arst_pixel_en", pixel_en, 0);
        check("arst_frame_start", frame_start, 0);
        repeat (2) tick();
        check("arst_hold_frame_start", frame_start, 0);
        @(negedge clk) rst = 1'b1;
        repeat (4) tick();
        check("restart_hcount", hcount, 1);
        check("restart_vcount", vcount, 0);
        check("restart_frame_start", frame_start, 0);

        // Small raster: raster position after release edge k is k-1.
        hs_cnt = 0;
        vs_cnt = 0;
        fs_cnt = 0;
        @(negedge clk) rst_s = 1'b1;
        for (int k = 1; k <= 250; k++) begin
            tick();
            p  = k - 1;
            he = p % 15;
            ve = (p / 15) % 8;
            check("s_pixel_en", pixel_en_s, 1);
            check("s_hcount", hcount_s, he);
            check("s_vcount", vcount_s, ve);
            check("s_hsync", hsync_s, (he >= 10 && he <= 12) ? 1 : 0);
            check("s_vsync", vsync_s, (ve >= 5 && ve <= 6) ? 1 : 0);
            check("s_blanking", blanking_s, (he >= 8 || ve >= 4) ? 1 : 0);
            check("s_frame_start", frame_start_s, (p == 120 || p == 240) ? 1 : 0);
`ifdef VGA_FRAME_COUNT_EN
            check("s_frame_count", frame_count_s, ((p > 120) ? 1 : 0) + ((p > 240) ? 1 : 0));
`endif
            if (p < 15 && hsync_s) hs_cnt++;
            if (p < 120 && vsync_s) vs_cnt++;
            if (frame_start_s) fs_cnt++;
        end
        check("s_hsync_clks_per_line", hs_cnt, 3);
        check("s_vsync_clks_per_frame", vs_cnt, 30);
        check("s_frame_start_pulses", fs_cnt, 2);

`ifdef VGA_FRAME_COUNT_EN
        // 257 wraps: last pulse at p=257*120, counted one clk later.
        repeat (257 * 120 + 1 - 249) tick();
        check("s_frame_count_257", frame_count_s, 1);
        check("dflt_frame_count", frame_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing (hsync, vsync, blanking, pixel coordinates) from the 100 MHz board clock.
- It is the source of the `blanking` signal that the colour/pixel generators consume.
- It also drives the Basys3 Hsync/Vsync pins.
- Default parameters give 640x480 @ 60 Hz, with a 25 MHz pixel rate derived by clock-enable (no derived clocks).

Parameters:
- CLK_DIV, 4, system clocks per pixel; legal range 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous assert, active-low.
- pixel_en  out  1  one-clk pulse every CLK_DIV clocks; marks a pixel slot.
- hcount  out  10  current pixel column, 0..H_TOTAL-1.
- vcount  out  10  current line, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- blanking  out  1  1 = outside the visible area; colour must be driven 0.
- frame_start  out  1  one-clk pulse when the raster wraps to (0,0).

Behaviour:
- Derived widths: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525). Both must be <= 1024; elaboration fails otherwise.
- Reset (rst=0, async), applied immediately:
  - divider=0, hcount=0, vcount=0, pixel_en=0, frame_start=0.
  - blanking=1.
  - hsync=vsync=~SYNC_ACTIVE.
  - Reset mid-frame abandons the frame; no frame_start pulse is emitted for it.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixel_en is high while divider==CLK_DIV-1. With the default, the first pulse occurs on the 4th clk after reset release.
  - CLK_DIV=1: pixel_en is constantly 1 after release.
- Counter FSM (advances only on a clk edge where pixel_en=1):
  - hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount at V_TOTAL-1 with hcount wrap → vcount=0.
- Registered decode, updated on the same edge as the counters and computed from the next counter values, so it is always aligned with hcount/vcount (0 cycles skew):
  - blanking = (hcount>=H_ACTIVE) | (vcount>=V_ACTIVE).
  - hsync = SYNC_ACTIVE when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync = SYNC_ACTIVE when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 490..491).
  - frame_start = 1 for exactly one clk: the clk after the edge where the counters wrapped (524,799)→(0,0).
- Outputs hold between pixel_en pulses.
- Downstream colour logic registers colour one clk after sampling blanking. This is accepted: with CLK_DIV>=2 it stays inside the pixel slot.
- Frame period (default) = 800*525*4 = 1,680,000 clks.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - Adds output port frame_count [7:0].
  - Reset 0; increments on each frame_start; wraps 255→0.
  - Used for animation and test-pattern stepping.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package vga_pkg:
  - Default 640x480 timing constants.
  - H_TOTAL/V_TOTAL computation.
  - 10-bit coordinate width constant.
  - Colour-width constant (4), shared with the colour generators.
- Sub-module pixel_tick_gen:
  - Parameter CLK_DIV; ports clk, rst, tick.
  - Reusable for button sampling and debouncing.

Test Plan:
- Reset release, defaults → pixel_en first high on clk 4, then every 4th clk; hcount=1 after the first pixel_en edge; blanking=1 during reset and 0 at (0,0) after release.
- Run one line → hsync low exactly for hcount 656..751 (96 pixels = 384 clks); blanking=1 for hcount 640..799; hcount wraps 799→0 and vcount 0→1.
- Run one full frame → vsync low for vcount 490..491 (1600 pixel slots); frame_start pulses once, 1,680,000 clks after the first pixel_en edge, one clk wide.
- Assert rst at hcount=300, vcount=200 → all outputs return to reset values asynchronously (before the next clk edge); no frame_start; timing restarts from (0,0) after release.
- CLK_DIV=1, SYNC_ACTIVE=1 → pixel_en constantly 1; hsync high for 96 consecutive clks per 800-clk line.
- With VGA_FRAME_COUNT_EN, 257 frames → frame_count increments per frame_start and reads 1 after wrap.
